m2v_idct_outbuf: RTL and testbench

Parametrised multi-bank result buffer between the IDCT column stage and the pixel reader (MC/reconstruction).
- Supersedes the fixed two-lane, single-buffer pixel port.
- Generalises lane count, in-flight block depth and output width.
- Adds per-bank coded tracking, saturation and an overrun error flag.
- Uncoded blocks occupy a bank but store no samples; reads of an uncoded bank return zero.

---
 rtl/m2v_idct_pkg.sv | 25 ++
 rtl/m2v_idct_outbuf_ram.sv | 22 ++
 rtl/m2v_idct_outbuf.sv | 164 ++++++++++++++++
 tb/tb_m2v_idct_outbuf.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m2v_idct_pkg.sv
// rtl/m2v_idct_pkg.sv - shared types and helpers for the IDCT output buffer
package m2v_idct_pkg;

   localparam int BLK_SAMPLES = 64;

   typedef enum logic [1:0] {
      FREE,
      FILLING,
      FULL,
      READING
   } bank_state_e;

   // Clamp a sign-extended sample into the signed range of an ow-bit result.
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int unsigned ow);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (ow - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/m2v_idct_outbuf_ram.sv
// rtl/m2v_idct_outbuf_ram.sv - simple dual-port sample RAM with registered read
module m2v_idct_outbuf_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 18
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/m2v_idct_outbuf.sv
// rtl/m2v_idct_outbuf.sv - multi-bank IDCT result buffer feeding the pixel reader
module m2v_idct_outbuf
   import m2v_idct_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int NBANKS = 2,
   parameter int IW     = 16,
   parameter int OW     = 9,
   localparam int WPB   = BLK_SAMPLES / LANES,
   localparam int AW    = $clog2(WPB),
   localparam int PW    = $clog2(NBANKS),
   localparam int LW    = PW + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                softreset,
   output logic                ready,
   input  logic                blk_start,
   input  logic                blk_coded,
   input  logic                wr_valid,
   input  logic [LANES*IW-1:0] wr_data,
   input  logic                rd_start,
   output logic                rd_avail,
   output logic                rd_coded,
   input  logic [AW-1:0]       rd_addr,
   output logic [LANES*OW-1:0] rd_data,
   input  logic                rd_done,
   output logic                err_ovr,
   output logic [LW-1:0]       level
);

   bank_state_e       bank_q [NBANKS];
   bank_state_e       bank_d [NBANKS];
   logic [NBANKS-1:0] coded_q, coded_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     beat_q, beat_d;
   logic [LW-1:0]     level_q, level_d;
   logic              err_q, err_d;
   logic              rd_coded_q, rd_coded_d;
   logic              rd_en_q, rd_en_d;

   logic              filling, reading, claim, wr_fire, wr_last, rd_open, rd_rel;
   logic [LANES*OW-1:0] wr_word;
   logic [LANES*OW-1:0] ram_rdata;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NBANKS - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ring order keeps the FILLING bank at wr_ptr and the oldest block at rd_ptr.
   assign filling = (bank_q[wr_ptr_q] == FILLING);
   assign reading = (bank_q[rd_ptr_q] == READING);
   assign ready   = (level_q < LW'(NBANKS));
   assign claim   = blk_start && ready && !filling;
   assign wr_fire = wr_valid && filling;
   assign wr_last = wr_fire && (beat_q == AW'(WPB - 1));
   assign rd_open = rd_start && !reading && (bank_q[rd_ptr_q] == FULL);
   assign rd_rel  = rd_done && reading;

   always_comb begin
      rd_avail = 1'b0;
      for (int i = 0; i < NBANKS; i++) begin
         if (bank_q[i] == FULL) rd_avail = 1'b1;
      end
   end

   always_comb begin
      wr_word = '0;
      for (int l = 0; l < LANES; l++) begin
         wr_word[l*OW +: OW] = OW'(sat_signed(32'(signed'(wr_data[l*IW +: IW])), OW));
      end
   end

   always_comb begin
      bank_d     = bank_q;
      coded_d    = coded_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      beat_d     = beat_q;
      rd_coded_d = rd_coded_q;
      level_d    = level_q + LW'(claim) - LW'(rd_rel);
      err_d      = err_q | (blk_start && !claim) | (wr_valid && !filling);
      rd_en_d    = reading && rd_coded_q;

      if (claim) begin
         bank_d[wr_ptr_q]  = blk_coded ? FILLING : FULL;
         coded_d[wr_ptr_q] = blk_coded;
         beat_d            = '0;
         if (!blk_coded) wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (wr_fire) begin
         beat_d = beat_q + 1'b1;
         if (wr_last) begin
            bank_d[wr_ptr_q] = FULL;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
         end
      end
      if (rd_open) begin
         bank_d[rd_ptr_q] = READING;
         rd_coded_d       = coded_q[rd_ptr_q];
      end
      if (rd_rel) begin
         bank_d[rd_ptr_q] = FREE;
         rd_ptr_d         = ptr_inc(rd_ptr_q);
      end

      if (softreset) begin
         for (int i = 0; i < NBANKS; i++) bank_d[i] = FREE;
         coded_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         beat_d     = '0;
         level_d    = '0;
         err_d      = 1'b0;
         rd_coded_d = 1'b0;
         rd_en_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NBANKS; i++) bank_q[i] <= FREE;
         coded_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         beat_q     <= '0;
         level_q    <= '0;
         err_q      <= 1'b0;
         rd_coded_q <= 1'b0;
         rd_en_q    <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         coded_q    <= coded_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         beat_q     <= beat_d;
         level_q    <= level_d;
         err_q      <= err_d;
         rd_coded_q <= rd_coded_d;
         rd_en_q    <= rd_en_d;
      end
   end

   m2v_idct_outbuf_ram #(
      .DEPTH (NBANKS * WPB),
      .AW    (PW + AW),
      .DW    (LANES * OW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_fire),
      .waddr_i ({wr_ptr_q, beat_q}),
      .wdata_i (wr_word),
      .raddr_i ({rd_ptr_q, rd_addr}),
      .rdata_o (ram_rdata)
   );

   // Uncoded banks keep stale RAM contents; the registered enable masks them to zero.
   assign rd_data  = rd_en_q ? ram_rdata : '0;
   assign rd_coded = rd_coded_q;
   assign err_ovr  = err_q;
   assign level    = level_q;

endmodule

// File: tb/tb_m2v_idct_outbuf.sv
// tb/tb_m2v_idct_outbuf.sv - directed bench for the IDCT output buffer
module tb_m2v_idct_outbuf;

   logic        clk;
   logic        reset_n;

   logic        a_softreset, a_ready, a_blk_start, a_blk_coded, a_wr_valid;
   logic        a_rd_start, a_rd_avail, a_rd_coded, a_rd_done, a_err_ovr;
   logic [31:0] a_wr_data;
   logic [4:0]  a_rd_addr;
   logic [17:0] a_rd_data;
   logic [1:0]  a_level;

   logic        b_softreset, b_ready, b_blk_start, b_blk_coded, b_wr_valid;
   logic        b_rd_start, b_rd_avail, b_rd_coded, b_rd_done, b_err_ovr;
   logic [63:0] b_wr_data;
   logic [3:0]  b_rd_addr;
   logic [35:0] b_rd_data;
   logic [2:0]  b_level;

   logic [9:0]  b_pat;
   int          total;
   int          bad;

   m2v_idct_outbuf #(.LANES(2), .NBANKS(2), .IW(16), .OW(9)) u_a (
      .clk(clk), .reset_n(reset_n), .softreset(a_softreset), .ready(a_ready),
      .blk_start(a_blk_start), .blk_coded(a_blk_coded), .wr_valid(a_wr_valid),
      .wr_data(a_wr_data), .rd_start(a_rd_start), .rd_avail(a_rd_avail),
      .rd_coded(a_rd_coded), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .rd_done(a_rd_done), .err_ovr(a_err_ovr), .level(a_level)
   );

   m2v_idct_outbuf #(.LANES(4), .NBANKS(4), .IW(16), .OW(9)) u_b (
      .clk(clk), .reset_n(reset_n), .softreset(b_softreset), .ready(b_ready),
      .blk_start(b_blk_start), .blk_coded(b_blk_coded), .wr_valid(b_wr_valid),
      .wr_data(b_wr_data), .rd_start(b_rd_start), .rd_avail(b_rd_avail),
      .rd_coded(b_rd_coded), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_done(b_rd_done), .err_ovr(b_err_ovr), .level(b_level)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] a_word(input int v0, input int v1);
      return {9'(v1), 9'(v0)};
   endfunction

   task automatic a_fill(input int first, input int n, input int off, input int step);
      for (int b = first; b < first + n; b++) begin
         a_wr_valid = 1'b1;
         a_wr_data  = {16'(off + step * (2 * b + 1)), 16'(off + step * (2 * b))};
         tick;
      end
      a_wr_valid = 1'b0;
   endtask

   task automatic a_blk(input logic coded);
      a_blk_start = 1'b1;
      a_blk_coded = coded;
      tick;
      a_blk_start = 1'b0;
      a_blk_coded = 1'b0;
   endtask

   task automatic a_pulse_rd_start;
      a_rd_start = 1'b1;
      tick;
      a_rd_start = 1'b0;
   endtask

   task automatic a_pulse_rd_done;
      a_rd_done = 1'b1;
      tick;
      a_rd_done = 1'b0;
   endtask

   function automatic int sat9(input int x);
      if (x > 255) return 255;
      if (x < -256) return -256;
      return x;
   endfunction

   function automatic int b_sample(input int k, input int w, input int l);
      return k * 64 + w * 4 + l - 300;
   endfunction

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      total = 0;
      bad = 0;
      b_pat = 10'b1100101101;
      a_softreset = 0; a_blk_start = 0; a_blk_coded = 0; a_wr_valid = 0; a_wr_data = '0;
      a_rd_start = 0; a_rd_addr = '0; a_rd_done = 0;
      b_softreset = 0; b_blk_start = 0; b_blk_coded = 0; b_wr_valid = 0; b_wr_data = '0;
      b_rd_start = 0; b_rd_addr = '0; b_rd_done = 0;
      repeat (3) tick;
      reset_n = 1'b1;
      tick;

      chk("rst_ready", a_ready, 1);
      chk("rst_level", a_level, 0);
      chk("rst_rd_avail", a_rd_avail, 0);
      chk("rst_rd_coded", a_rd_coded, 0);
      chk("rst_rd_data", a_rd_data, 0);
      chk("rst_err", a_err_ovr, 0);
      chk("rst_b_level", b_level, 0);
      chk("rst_b_ready", b_ready, 1);

      // coded block, raster ramp 0..63
      a_blk(1'b1);
      chk("t1_level_filling", a_level, 1);
      a_fill(0, 32, 0, 1);
      chk("t1_rd_avail", a_rd_avail, 1);
      chk("t1_level_full", a_level, 1);
      a_pulse_rd_start;
      chk("t1_rd_coded", a_rd_coded, 1);
      for (int a = 0; a < 32; a++) begin
         a_rd_addr = 5'(a);
         tick;
         chk($sformatf("t1_rd_data[%0d]", a), a_rd_data, a_word(2 * a, 2 * a + 1));
      end
      a_pulse_rd_done;
      chk("t1_level_done", a_level, 0);
      chk("t1_rd_avail_done", a_rd_avail, 0);

      // saturation
      a_blk(1'b1);
      a_wr_valid = 1'b1;
      a_wr_data = {16'hFED4, 16'd300};   tick;
      a_wr_data = {16'hFF00, 16'd255};   tick;
      a_wr_data = {16'h8000, 16'h7FFF};  tick;
      a_wr_data = '0;
      for (int b = 3; b < 32; b++) tick;
      a_wr_valid = 1'b0;
      chk("t2_rd_avail", a_rd_avail, 1);
      a_pulse_rd_start;
      a_rd_addr = 5'd0;  tick; chk("t2_sat_w0", a_rd_data, {9'h100, 9'h0FF});
      a_rd_addr = 5'd1;  tick; chk("t2_sat_w1", a_rd_data, {9'h100, 9'h0FF});
      a_rd_addr = 5'd2;  tick; chk("t2_sat_w2", a_rd_data, {9'h100, 9'h0FF});
      a_rd_addr = 5'd31; tick; chk("t2_sat_w31", a_rd_data, 0);
      a_pulse_rd_done;

      // uncoded block lands on bank 0, which still holds the ramp
      a_blk(1'b0);
      chk("t3_rd_avail", a_rd_avail, 1);
      chk("t3_level", a_level, 1);
      chk("t3_ready", a_ready, 1);
      a_pulse_rd_start;
      chk("t3_rd_coded", a_rd_coded, 0);
      a_rd_addr = 5'd0;  tick; chk("t3_zero_w0", a_rd_data, 0);
      a_rd_addr = 5'd31; tick; chk("t3_zero_w31", a_rd_data, 0);
      a_pulse_rd_done;
      chk("t3_level_done", a_level, 0);
      chk("t3_err", a_err_ovr, 0);

      // full and overrun
      a_blk(1'b1);
      a_fill(0, 32, 7, 0);
      a_blk(1'b0);
      chk("t4_ready_full", a_ready, 0);
      chk("t4_level_full", a_level, 2);
      chk("t4_err_before", a_err_ovr, 0);
      a_blk(1'b1);
      chk("t4_err_ovr", a_err_ovr, 1);
      chk("t4_level_hold", a_level, 2);
      a_pulse_rd_start;
      chk("t4_rd_coded", a_rd_coded, 1);
      a_rd_addr = 5'd5; tick; chk("t4_rd_data", a_rd_data, a_word(7, 7));
      a_rd_done = 1'b1;
      a_blk_start = 1'b1;
      a_blk_coded = 1'b0;
      tick;
      a_rd_done = 1'b0;
      a_blk_start = 1'b0;
      chk("t4_same_cycle_level", a_level, 1);
      chk("t4_ready_back", a_ready, 1);
      a_pulse_rd_start;
      chk("t4_rd_coded_unc", a_rd_coded, 0);
      a_pulse_rd_done;
      chk("t4_level_empty", a_level, 0);

      // softreset during beat 10 while another bank is being read
      a_blk(1'b1);
      a_fill(0, 32, 3, 0);
      a_pulse_rd_start;
      a_rd_addr = 5'd0;
      a_blk(1'b1);
      chk("t6_rd_data_live", a_rd_data, a_word(3, 3));
      chk("t6_level_busy", a_level, 2);
      a_fill(0, 10, 50, 1);
      a_softreset = 1'b1;
      a_wr_valid = 1'b1;
      a_wr_data = 32'h0001_0001;
      tick;
      a_softreset = 1'b0;
      a_wr_valid = 1'b0;
      chk("t6_level", a_level, 0);
      chk("t6_ready", a_ready, 1);
      chk("t6_rd_avail", a_rd_avail, 0);
      chk("t6_rd_data", a_rd_data, 0);
      chk("t6_rd_coded", a_rd_coded, 0);
      chk("t6_err_clear", a_err_ovr, 0);
      a_blk(1'b1);
      a_fill(0, 31, 100, 1);
      chk("t6_not_yet_full", a_rd_avail, 0);
      a_fill(31, 1, 100, 1);
      chk("t6_full", a_rd_avail, 1);
      a_pulse_rd_start;
      chk("t6_rd_coded_new", a_rd_coded, 1);
      a_rd_addr = 5'd0;  tick; chk("t6_w0", a_rd_data, a_word(100, 101));
      a_rd_addr = 5'd17; tick; chk("t6_w17", a_rd_data, a_word(134, 135));
      a_rd_addr = 5'd31; tick; chk("t6_w31", a_rd_data, a_word(162, 163));
      a_pulse_rd_done;
      chk("t6_level_done", a_level, 0);
      a_wr_valid = 1'b1;
      tick;
      a_wr_valid = 1'b0;
      chk("t6_stray_wr_err", a_err_ovr, 1);

      // 4 lanes x 4 banks: writer and reader run concurrently over 10 blocks
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               int n;
               n = 0;
               while (!b_ready && n < 2000) begin
                  tick;
                  n++;
               end
               chk($sformatf("b_ready_wait[%0d]", k), b_ready, 1);
               b_blk_start = 1'b1;
               b_blk_coded = b_pat[k];
               tick;
               b_blk_start = 1'b0;
               b_blk_coded = 1'b0;
               if (b_pat[k]) begin
                  for (int w = 0; w < 16; w++) begin
                     logic [63:0] d;
                     for (int l = 0; l < 4; l++) d[l*16 +: 16] = 16'(b_sample(k, w, l));
                     b_wr_valid = 1'b1;
                     b_wr_data = d;
                     tick;
                  end
                  b_wr_valid = 1'b0;
               end
            end
         end
         begin
            for (int k = 0; k < 10; k++) begin
               int n;
               n = 0;
               while (!b_rd_avail && n < 2000) begin
                  tick;
                  n++;
               end
               chk($sformatf("b_avail_wait[%0d]", k), b_rd_avail, 1);
               b_rd_start = 1'b1;
               tick;
               b_rd_start = 1'b0;
               chk($sformatf("b_rd_coded[%0d]", k), b_rd_coded, b_pat[k]);
               for (int w = 0; w < 16; w++) begin
                  logic [35:0] e;
                  for (int l = 0; l < 4; l++)
                     e[l*9 +: 9] = b_pat[k] ? 9'(sat9(b_sample(k, w, l))) : 9'd0;
                  b_rd_addr = 4'(w);
                  tick;
                  chk($sformatf("b_rd_data[%0d][%0d]", k, w), b_rd_data, e);
               end
               b_rd_done = 1'b1;
               tick;
               b_rd_done = 1'b0;
            end
         end
      join
      tick;
      chk("b_level_end", b_level, 0);
      chk("b_err_end", b_err_ovr, 0);
      chk("b_ready_end", b_ready, 1);
      chk("b_rd_avail_end", b_rd_avail, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
